// File: rtl/inventory_dispense.sv
// rtl/inventory_dispense.sv - vending stock owner: select/pay/service FSM, reduce and changeState responders.
// Optional SALES_COUNT_EN builds a saturating 16-bit dispense counter on salesTotal.
module inventory_dispense #(
  parameter int NUM_ITEMS  = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 selValid,
  input  logic [3:0]           selIndex,
  input  logic                 restock,
  input  logic                 restockValid,
  input  logic [3:0]           restockIndex,
  input  logic [STOCK_W-1:0]   restockCount,
  input  logic                 reduceInventory,
  output logic                 reduceInventoryDone,
  input  logic                 changeState,
  output logic                 changeStateDone,
  output logic [1:0]           state,
  output logic [3:0]           curIndex,
  output logic                 fullInventory,
  output logic                 dispense,
  output logic [3:0]           dispenseIndex,
  output logic [NUM_ITEMS-1:0] soldOut,
  output logic [15:0]          salesTotal
);

  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam logic [STOCK_W-1:0] STOCK_MAX  = '1;
  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

  typedef enum logic [1:0] {
    ST_SELECT  = 2'b00,
    ST_PAY     = 2'b01,
    ST_SERVICE = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cur_q, cur_d;
  logic               red_done_q, red_done_d;
  logic               cs_done_q, cs_done_d;
  logic               disp_q, disp_d;
  logic [3:0]         disp_idx_q, disp_idx_d;
  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];
  logic [STOCK_W-1:0] cur_stock;
  logic [STOCK_W:0]   restock_sum;
  logic               cs_grant;

  function automatic logic idx_ok(input logic [3:0] idx);
    return {28'd0, idx} < $unsigned(NUM_ITEMS);
  endfunction

  assign cur_stock   = stock_q[cur_q[IDX_W-1:0]];
  assign restock_sum = {1'b0, stock_q[restockIndex[IDX_W-1:0]]} + {1'b0, restockCount};
  // The state grant waits for the reduce handshake to be fully idle so reduce is always served first.
  assign cs_grant    = changeState && !cs_done_q && !reduceInventory && !red_done_q &&
                       (state_q != ST_SERVICE);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    red_done_d = red_done_q;
    cs_done_d  = cs_done_q;
    disp_d     = 1'b0;
    disp_idx_d = disp_idx_q;
    stock_d    = stock_q;

    case (state_q)
      ST_SELECT: begin
        if (restock) begin
          state_d = ST_SERVICE;
        end else if (selValid && idx_ok(selIndex)) begin
          cur_d   = selIndex;
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (reduceInventory && !red_done_q) begin
          red_done_d = 1'b1;
          if (cur_stock != '0) begin
            stock_d[cur_q[IDX_W-1:0]] = cur_stock - 1'b1;
            disp_d     = 1'b1;
            disp_idx_d = cur_q;
          end
        end
        if (cs_grant) begin
          state_d = ST_SELECT;
        end
      end
      ST_SERVICE: begin
        if (restockValid && idx_ok(restockIndex)) begin
          stock_d[restockIndex[IDX_W-1:0]] = restock_sum[STOCK_W] ? STOCK_MAX
                                                                  : restock_sum[STOCK_W-1:0];
        end
        if (!restock) begin
          state_d = ST_SELECT;
        end
      end
      default: state_d = ST_SELECT;
    endcase

    if (!reduceInventory && red_done_q) begin
      red_done_d = 1'b0;
    end
    if (cs_grant) begin
      cs_done_d = 1'b1;
    end else if (!changeState) begin
      cs_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_SELECT;
      cur_q      <= '0;
      red_done_q <= 1'b0;
      cs_done_q  <= 1'b0;
      disp_q     <= 1'b0;
      disp_idx_q <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_INIT;
      end
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      red_done_q <= red_done_d;
      cs_done_q  <= cs_done_d;
      disp_q     <= disp_d;
      disp_idx_q <= disp_idx_d;
      stock_q    <= stock_d;
    end
  end

`ifdef SALES_COUNT_EN
  logic [15:0] sales_q, sales_d;

  always_comb begin
    sales_d = sales_q;
    if (disp_d && (sales_q != 16'hFFFF)) begin
      sales_d = sales_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sales_q <= '0;
    end else begin
      sales_q <= sales_d;
    end
  end

  assign salesTotal = sales_q;
`else
  assign salesTotal = '0;
`endif

  always_comb begin
    soldOut = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      soldOut[i] = (stock_q[i] == '0);
    end
  end

  assign state               = state_q;
  assign curIndex            = cur_q;
  assign fullInventory       = (cur_stock != '0);
  assign dispense            = disp_q;
  assign dispenseIndex       = disp_idx_q;
  assign reduceInventoryDone = red_done_q;
  assign changeStateDone     = cs_done_q;

endmodule

// File: tb/tb_inventory_dispense.sv
// tb/tb_inventory_dispense.sv - directed self-checking bench for inventory_dispense.
module tb_inventory_dispense;

  logic       clk = 1'b0;
  logic       rst;
  logic       selValid, restock, restockValid, reduceInventory, changeState;
  logic [3:0] selIndex, restockIndex, restockCount;
  logic       reduceInventoryDone, changeStateDone, fullInventory, dispense;
  logic [1:0] state;
  logic [3:0] curIndex, dispenseIndex;
  logic [7:0] soldOut;
  logic [15:0] salesTotal;

  int checks = 0;
  int failures = 0;
  int exp_sales = 0;

  always #5 clk = ~clk;

  inventory_dispense dut (
    .clk(clk), .rst(rst),
    .selValid(selValid), .selIndex(selIndex),
    .restock(restock), .restockValid(restockValid),
    .restockIndex(restockIndex), .restockCount(restockCount),
    .reduceInventory(reduceInventory), .reduceInventoryDone(reduceInventoryDone),
    .changeState(changeState), .changeStateDone(changeStateDone),
    .state(state), .curIndex(curIndex), .fullInventory(fullInventory),
    .dispense(dispense), .dispenseIndex(dispenseIndex),
    .soldOut(soldOut), .salesTotal(salesTotal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    selValid = 0; selIndex = 0; restock = 0; restockValid = 0;
    restockIndex = 0; restockCount = 0; reduceInventory = 0; changeState = 0;
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_cur", 32'(curIndex), 32'd0);
    check("rst_rdone", 32'(reduceInventoryDone), 32'd0);
    check("rst_cdone", 32'(changeStateDone), 32'd0);
    check("rst_disp", 32'(dispense), 32'd0);
    check("rst_soldout", 32'(soldOut), 32'd0);
    check("rst_sales", 32'(salesTotal), 32'd0);
    check("rst_full", 32'(fullInventory), 32'd1);
    for (int i = 0; i < 8; i++) check($sformatf("rst_stock%0d", i), 32'(dut.stock_q[i]), 32'd5);
    rst = 1'b1;
    tick();

    // out-of-range select ignored
    selValid = 1; selIndex = 4'd9; tick(); selValid = 0;
    check("oor_state", 32'(state), 32'd0);
    selValid = 1; selIndex = 4'd3; tick(); selValid = 0;
    check("sel_state", 32'(state), 32'd1);
    check("sel_cur", 32'(curIndex), 32'd3);

    // single purchase of item 3, request held high after Done
    reduceInventory = 1; tick();
    exp_sales++;
    check("r1_done", 32'(reduceInventoryDone), 32'd1);
    check("r1_disp", 32'(dispense), 32'd1);
    check("r1_didx", 32'(dispenseIndex), 32'd3);
    check("r1_stock3", 32'(dut.stock_q[3]), 32'd4);
    tick();
    check("r1_hold_done", 32'(reduceInventoryDone), 32'd1);
    check("r1_hold_disp", 32'(dispense), 32'd0);
    check("r1_hold_stock3", 32'(dut.stock_q[3]), 32'd4);
    reduceInventory = 0; tick();
    check("r1_rel_done", 32'(reduceInventoryDone), 32'd0);

    // simultaneous reduce and changeState: reduce served first
    reduceInventory = 1; changeState = 1; tick();
    exp_sales++;
    check("sim_rdone", 32'(reduceInventoryDone), 32'd1);
    check("sim_cdone0", 32'(changeStateDone), 32'd0);
    check("sim_state0", 32'(state), 32'd1);
    check("sim_stock3", 32'(dut.stock_q[3]), 32'd3);
    reduceInventory = 0; tick();
    check("sim_rdone_clr", 32'(reduceInventoryDone), 32'd0);
    check("sim_cdone1", 32'(changeStateDone), 32'd0);
    tick();
    check("sim_cdone2", 32'(changeStateDone), 32'd1);
    check("sim_state2", 32'(state), 32'd0);
    changeState = 0; tick();
    check("sim_cdone_clr", 32'(changeStateDone), 32'd0);

    // five purchases of item 0
    for (int n = 0; n < 5; n++) begin
      selValid = 1; selIndex = 4'd0; tick(); selValid = 0;
      reduceInventory = 1; tick();
      exp_sales++;
      check($sformatf("buy%0d_disp", n), 32'(dispense), 32'd1);
      reduceInventory = 0; tick();
      changeState = 1; tick();
      changeState = 0; tick();
    end
    check("buy_stock0", 32'(dut.stock_q[0]), 32'd0);
    check("buy_soldout", 32'(soldOut), 32'h01);
    selValid = 1; selIndex = 4'd0; tick(); selValid = 0;
    check("six_full", 32'(fullInventory), 32'd0);
    reduceInventory = 1; tick();
    check("six_done", 32'(reduceInventoryDone), 32'd1);
    check("six_disp", 32'(dispense), 32'd0);
    check("six_stock0", 32'(dut.stock_q[0]), 32'd0);
    reduceInventory = 0; tick();
    changeState = 1; tick();
    changeState = 0; tick();
    check("six_state", 32'(state), 32'd0);
`ifdef SALES_COUNT_EN
    check("sales", 32'(salesTotal), 32'(exp_sales));
`else
    check("sales_off", 32'(salesTotal), 32'd0);
`endif

    // service mode: restock wins over select in the same cycle
    restock = 1; selValid = 1; selIndex = 4'd1; tick(); selValid = 0;
    check("svc_state", 32'(state), 32'd3);
    restockValid = 1; restockIndex = 4'd2; restockCount = 4'd15; tick();
    restockIndex = 4'd0; restockCount = 4'd3; tick();
    restockValid = 0;
    check("svc_stock2_sat", 32'(dut.stock_q[2]), 32'd15);
    check("svc_stock0", 32'(dut.stock_q[0]), 32'd3);
    check("svc_soldout", 32'(soldOut), 32'd0);
    restock = 0; tick();
    check("svc_exit", 32'(state), 32'd0);

    // asynchronous reset while reduce acknowledge is high
    selValid = 1; selIndex = 4'd2; tick(); selValid = 0;
    reduceInventory = 1; tick();
    check("ar_done_pre", 32'(reduceInventoryDone), 32'd1);
    check("ar_stock2_pre", 32'(dut.stock_q[2]), 32'd14);
    #2 rst = 1'b0;
    #1;
    check("ar_done", 32'(reduceInventoryDone), 32'd0);
    check("ar_stock2", 32'(dut.stock_q[2]), 32'd5);
    check("ar_stock0", 32'(dut.stock_q[0]), 32'd5);
    check("ar_state", 32'(state), 32'd0);
    tick();
    check("ar_disp", 32'(dispense), 32'd0);
    check("ar_sales", 32'(salesTotal), 32'd0);
    reduceInventory = 0;
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
